// File: rtl/digital_filter.sv
// First-order Q16.16 IIR stage: y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1].
// Single-cycle recursion with wide accumulation, floor rescale and output saturation.
module digital_filter #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] b0,
   input  logic [DATA_W-1:0] b1,
   output logic [DATA_W-1:0] yn
);

   localparam int PW = 2 * DATA_W;
   localparam int SW = 2 * DATA_W + 2;

   logic [DATA_W-1:0]        x_d;
   logic [DATA_W-1:0]        y_q;
   logic signed [PW-1:0]     p_b0, p_b1, p_a1;
   logic signed [SW-1:0]     sum;
   logic signed [SW-1:0]     y_sh;
   logic [SW-DATA_W:0]       y_hi;
   logic [DATA_W-1:0]        y_sat;

   function automatic logic signed [PW-1:0] sext(input logic [DATA_W-1:0] v);
      return $signed({{DATA_W{v[DATA_W-1]}}, v});
   endfunction

   // Operands widened first so each product is the exact 2*DATA_W result
   assign p_b0 = sext(b0) * sext(data_in);
   assign p_b1 = sext(b1) * sext(x_d);
   assign p_a1 = sext(a1) * sext(y_q);

   assign sum  = $signed({{2{p_b0[PW-1]}}, p_b0})
               + $signed({{2{p_b1[PW-1]}}, p_b1})
               + $signed({{2{p_a1[PW-1]}}, p_a1});

   assign y_sh = sum >>> FRAC_W;
   assign y_hi = y_sh[SW-1:DATA_W-1];

   // In range only when every bit above the result's sign bit matches it
   always_comb begin
      y_sat = y_sh[DATA_W-1:0];
      if (!((&y_hi) || !(|y_hi)))
         y_sat = y_sh[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_d <= '0;
         y_q <= '0;
      end else begin
         x_d <= data_in;
         y_q <= y_sat;
      end
   end

   assign yn = y_q;

endmodule

// File: tb/tb_digital_filter.sv
// Directed bench for digital_filter: reset, low/high-pass responses, saturation and floor rescale.
module tb_digital_filter;

   logic        clk;
   logic        rst;
   logic [31:0] data_in, a1, b0, b1;
   logic [31:0] yn;

   int checks;
   int failures;

   digital_filter #(.DATA_W(32), .FRAC_W(16)) dut (
      .clk(clk), .rst(rst), .data_in(data_in),
      .a1(a1), .b0(b0), .b1(b1), .yn(yn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      step();
      rst = 1'b1;
   endtask

   task automatic set_coef(input logic [31:0] ca1, input logic [31:0] cb0, input logic [31:0] cb1);
      a1 = ca1; b0 = cb0; b1 = cb1;
   endtask

   task automatic test_reset();
      set_coef(32'h0000FEFF, 32'h80, 32'h80);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         data_in = $urandom;
         step();
      end
      checks++;
      if (yn !== 32'h0) begin
         failures++;
         $display("FAIL reset_hold yn=%h expected=%h", yn, 32'h0);
      end
      rst = 1'b1;
      data_in = 32'h10000;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (yn === 32'h0) begin
         failures++;
         $display("FAIL reset_pre_async yn=%h expected nonzero", yn);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (yn !== 32'h0) begin
         failures++;
         $display("FAIL reset_async yn=%h expected=%h", yn, 32'h0);
      end
      step();
      rst = 1'b1;
      data_in = 32'h10000;
      step();
      checks++;
      if (yn !== 32'h80) begin
         failures++;
         $display("FAIL reset_first_edge yn=%h expected=%h", yn, 32'h80);
      end
   endtask

   task automatic test_lowpass_impulse();
      logic [31:0] exp_seq [4];
      logic [63:0] prod;
      logic [31:0] prev;
      int bad;
      exp_seq = '{32'h80, 32'hFF, 32'hFE, 32'hFD};
      set_coef(32'h0000FEFF, 32'h80, 32'h80);
      data_in = 32'h10000;
      do_reset();
      step();
      data_in = 32'h0;
      checks++;
      if (yn !== exp_seq[0]) begin
         failures++;
         $display("FAIL lp_impulse_0 yn=%h expected=%h", yn, exp_seq[0]);
      end
      for (int i = 1; i < 4; i++) begin
         step();
         checks++;
         if (yn !== exp_seq[i]) begin
            failures++;
            $display("FAIL lp_impulse_%0d yn=%h expected=%h", i, yn, exp_seq[i]);
         end
      end
      prev = 32'hFD;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         prod = 64'(prev) * 64'h0000FEFF;
         if (yn !== prod[47:16]) bad++;
         prev = prod[47:16];
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL lp_impulse_decay mismatched_cycles=%0d expected=0 last_yn=%h", bad, yn);
      end
   endtask

   task automatic test_lowpass_dc();
      logic [31:0] prev;
      int nonmono;
      set_coef(32'h0000FEFF, 32'h80, 32'h80);
      data_in = 32'h10000;
      do_reset();
      prev = 32'h0;
      nonmono = 0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if ($signed(yn) < $signed(prev)) nonmono++;
         prev = yn;
      end
      checks++;
      if (nonmono != 0) begin
         failures++;
         $display("FAIL lp_dc_monotonic drops=%0d expected=0", nonmono);
      end
      step();
      checks++;
      if (yn !== prev) begin
         failures++;
         $display("FAIL lp_dc_settled yn=%h expected=%h", yn, prev);
      end
      checks++;
      if (!($signed(yn) >= 32'sh0000FE02 && $signed(yn) <= 32'sh0000FEFF)) begin
         failures++;
         $display("FAIL lp_dc_final yn=%h expected in [0000fe02,0000feff]", yn);
      end
   endtask

   task automatic test_highpass_step();
      set_coef(32'h0000C035, 32'h0000E01A, 32'hFFFF1FE6);
      data_in = 32'h10000;
      do_reset();
      step();
      checks++;
      if (yn !== 32'h0000E01A) begin
         failures++;
         $display("FAIL hp_step_0 yn=%h expected=%h", yn, 32'h0000E01A);
      end
      step();
      checks++;
      if (yn !== 32'h0000A841) begin
         failures++;
         $display("FAIL hp_step_1 yn=%h expected=%h", yn, 32'h0000A841);
      end
      for (int i = 0; i < 98; i++) step();
      checks++;
      if (!($signed(yn) > -16 && $signed(yn) < 16)) begin
         failures++;
         $display("FAIL hp_step_decay yn=%h expected |yn|<10", yn);
      end
   endtask

   task automatic test_saturation();
      set_coef(32'h0, 32'h7FFFFFFF, 32'h0);
      data_in = 32'h7FFFFFFF;
      do_reset();
      step();
      checks++;
      if (yn !== 32'h7FFFFFFF) begin
         failures++;
         $display("FAIL sat_pos yn=%h expected=%h", yn, 32'h7FFFFFFF);
      end
      data_in = 32'h80000000;
      step();
      checks++;
      if (yn !== 32'h80000000) begin
         failures++;
         $display("FAIL sat_neg yn=%h expected=%h", yn, 32'h80000000);
      end
      // Feedback of a saturated value with unity gain must hold it exactly
      data_in = 32'h7FFFFFFF;
      step();
      set_coef(32'h00010000, 32'h0, 32'h0);
      data_in = 32'h0;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (yn !== 32'h7FFFFFFF) begin
         failures++;
         $display("FAIL sat_feedback yn=%h expected=%h", yn, 32'h7FFFFFFF);
      end
   endtask

   task automatic test_truncation();
      set_coef(32'h0, 32'h00010000, 32'h0);
      data_in = 32'hFFFFFFFF;
      do_reset();
      step();
      checks++;
      if (yn !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL trunc_unity yn=%h expected=%h", yn, 32'hFFFFFFFF);
      end
      set_coef(32'h0, 32'h00008000, 32'h0);
      step();
      checks++;
      if (yn !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL trunc_floor yn=%h expected=%h", yn, 32'hFFFFFFFF);
      end
      data_in = 32'hFFFF0000;
      step();
      checks++;
      if (yn !== 32'hFFFF8000) begin
         failures++;
         $display("FAIL trunc_half yn=%h expected=%h", yn, 32'hFFFF8000);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b0;
      data_in = '0;
      set_coef(32'h0, 32'h0, 32'h0);
      test_reset();
      test_lowpass_impulse();
      test_lowpass_dc();
      test_highpass_step();
      test_saturation();
      test_truncation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/digital_filter.md
Name: digital_filter

Overview:
- First-order fixed-point IIR filter stage with runtime coefficient inputs.
- Computes y[n] = b0·x[n] + b1·x[n-1] + a1·y[n-1], all values signed Q16.16.
- Fed one sample per clock from the synchronous sample ROM: 32768×32, 15-bit address, registered output, 1-cycle read latency.
- Two instances share one input stream: low-pass (a1=0xFEFF, b0=b1=0x80) and high-pass (a1=0xC035, b0=0xE01A, b1=0xFFFF1FE6).

Parameters:
- DATA_W, 32, width of data_in, coefficients and yn (two's complement).
- FRAC_W, 16, fractional bits of every operand; product rescale shift.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  signed Q16.16 sample x[n]; one new sample every cycle.
- a1  input  DATA_W  signed Q16.16 feedback coefficient, added (not subtracted).
- b0  input  DATA_W  signed Q16.16 coefficient on x[n].
- b1  input  DATA_W  signed Q16.16 coefficient on x[n-1].
- yn  output  DATA_W  signed Q16.16 filter output y[n], registered.

Behaviour:
- Reset:
  - rst low immediately (asynchronously) clears the x_d and y_q registers.
  - yn=0 while rst is low.
  - First rising edge after rst goes high processes data_in normally.
- Per rising edge (rst high):
  - sum = b0·data_in + b1·x_d + a1·y_q.
  - Each product is full 2·DATA_W signed; sum is held at 2·DATA_W+2 bits so it cannot overflow.
  - y_new = sum >>> FRAC_W (arithmetic shift, i.e. floor / truncation toward −inf; no rounding).
  - Saturate y_new to the signed DATA_W range [0x80000000, 0x7FFFFFFF].
  - Update y_q <= saturated y_new and x_d <= data_in.
- yn = y_q.
- Latency: yn reflects the data_in sampled at the preceding rising edge, so 1 cycle. No valid/ready handshake; every edge is a sample.
- Coefficients:
  - Sampled combinationally each edge.
  - Changing a coefficient mid-stream affects the next computed output only; stored state is kept.
- Feedback uses the saturated value, never the wrapped one.
- Datapath may be pipelined internally only if the 1-cycle data_in→yn latency and recursion are preserved.

Test Plan:
- Reset: drive rst=0 with random data_in → yn=0. Assert rst=0 asynchronously mid-stream → yn=0 before the next edge.
- Low-pass impulse: coefficients a1=0xFEFF, b0=b1=0x80; data_in=0x10000 for one cycle, then 0 → yn sequence 0x80, 0xFF, then monotonically decaying (0xFEFF·y>>16 each cycle) toward 0.
- Low-pass DC step: data_in held at 0x10000 from reset → yn rises monotonically, then becomes constant within 3000 cycles at a value in [0xFE02, 0xFEFF].
- High-pass step: coefficients a1=0xC035, b0=0xE01A, b1=0xFFFF1FE6; data_in held at 0x10000 → yn = 0xE01A, then 0xA841, then decays toward 0 (|yn| < 0x10 after 100 cycles).
- Saturation: b0=0x7FFFFFFF, a1=b1=0; data_in=0x7FFFFFFF → yn=0x7FFFFFFF. data_in=0x80000000 → yn=0x80000000.
- Negative truncation: b0=0x10000, a1=b1=0; data_in=0xFFFFFFFF → yn=0xFFFFFFFF. b0=0x8000 with data_in=0xFFFFFFFF → yn=0xFFFFFFFF (floor, not toward zero).
